branch_jump_unit: RTL and testbench

BRANCH_JUMP_UNIT -- requirements
Module: branch_jump_unit

---
 rtl/branch_jump_unit.sv | 187 ++++++++++++++++++
 tb/tb_branch_jump_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_jump_unit.sv
// rtl/branch_jump_unit.sv - branch/jump resolution with optional return-address stack
module branch_jump_unit #(
    parameter int RAS_DEPTH  = 4,
    parameter int ENABLE_RAS = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req,
    input  logic [3:0]                 path_index,
    input  logic [31:0]                pc,
    input  logic [25:0]                addr,
    input  logic [15:0]                imm,
    input  logic                       zero,
    input  logic [31:0]                reg_addr,
    input  logic                       use_ras,
    input  logic                       clr_flags,
    output logic [31:0]                pc_out,
    output logic [31:0]                link_addr,
    output logic                       link_we,
    output logic                       taken,
    output logic                       jump_done,
    output logic                       addr_err,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_ovf,
    output logic                       ras_unf
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);
    localparam logic RAS_ON = (ENABLE_RAS != 0);

    localparam logic [3:0] OP_BEQ = 4'd3;
    localparam logic [3:0] OP_BNE = 4'd4;
    localparam logic [3:0] OP_J   = 4'd5;
    localparam logic [3:0] OP_JAL = 4'd6;
    localparam logic [3:0] OP_JR  = 4'd8;

    // Circular buffer: ras_ptr_q points at the next free slot, so when full
    // it also points at the oldest entry and a push naturally overwrites it.
    logic [31:0]   ras_mem_q [RAS_DEPTH];
    logic [PW-1:0] ras_ptr_q, ras_ptr_d;
    logic [PW-1:0] ras_top_idx;
    logic [CW-1:0] ras_count_q, ras_count_d;
    logic          ras_ovf_q, ras_ovf_d;
    logic          ras_unf_q, ras_unf_d;

    logic [31:0]   pc_out_q, pc_out_d;
    logic [31:0]   link_addr_q, link_addr_d;
    logic          link_we_q, link_we_d;
    logic          taken_q, taken_d;
    logic          jump_done_q, jump_done_d;
    logic          addr_err_q, addr_err_d;

    logic [31:0]   pc4;
    logic [31:0]   br_off;
    logic [31:0]   jr_target;
    logic          push, pop, set_ovf, set_unf;

    // Resolve the request and work out the stack/flag side effects.
    always_comb begin
        pc4         = pc + 32'd4;
        br_off      = {{14{imm[15]}}, imm, 2'b00};
        ras_top_idx = ras_ptr_q - PW'(1);
        jr_target   = reg_addr;
        push        = 1'b0;
        pop         = 1'b0;
        set_ovf     = 1'b0;
        set_unf     = 1'b0;
        pc_out_d    = pc_out_q;
        link_addr_d = link_addr_q;
        taken_d     = taken_q;
        addr_err_d  = addr_err_q;
        link_we_d   = 1'b0;
        jump_done_d = 1'b0;
        ras_ptr_d   = ras_ptr_q;
        ras_count_d = ras_count_q;

        if (req) begin
            jump_done_d = 1'b1;
            addr_err_d  = 1'b0;
            taken_d     = 1'b0;
            pc_out_d    = pc4;
            case (path_index)
                OP_BEQ: if (zero) begin
                    pc_out_d = pc4 + br_off;
                    taken_d  = 1'b1;
                end
                OP_BNE: if (!zero) begin
                    pc_out_d = pc4 + br_off;
                    taken_d  = 1'b1;
                end
                OP_J: begin
                    pc_out_d = {pc4[31:28], addr, 2'b00};
                    taken_d  = 1'b1;
                end
                OP_JAL: begin
                    pc_out_d    = {pc4[31:28], addr, 2'b00};
                    taken_d     = 1'b1;
                    link_addr_d = pc4;
                    link_we_d   = 1'b1;
                    push        = RAS_ON;
                end
                OP_JR: begin
                    if (RAS_ON && use_ras) begin
                        if (ras_count_q != '0) begin
                            jr_target = ras_mem_q[ras_top_idx];
                            pop       = 1'b1;
                        end else begin
                            set_unf = 1'b1;
                        end
                    end
                    // A misaligned target falls through to the next instruction.
                    if (jr_target[1:0] != 2'b00) begin
                        addr_err_d = 1'b1;
                    end else begin
                        pc_out_d = jr_target;
                        taken_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (push) begin
            ras_ptr_d = ras_ptr_q + PW'(1);
            if (ras_count_q == RAS_FULL) begin
                set_ovf = 1'b1;
            end else begin
                ras_count_d = ras_count_q + CW'(1);
            end
        end
        if (pop) begin
            ras_ptr_d   = ras_top_idx;
            ras_count_d = ras_count_q - CW'(1);
        end

        // A new event wins over a simultaneous clear.
        ras_ovf_d = (ras_ovf_q & ~clr_flags) | set_ovf;
        ras_unf_d = (ras_unf_q & ~clr_flags) | set_unf;
    end

    // Output and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_out_q    <= '0;
            link_addr_q <= '0;
            link_we_q   <= 1'b0;
            taken_q     <= 1'b0;
            jump_done_q <= 1'b0;
            addr_err_q  <= 1'b0;
            ras_ptr_q   <= '0;
            ras_count_q <= '0;
            ras_ovf_q   <= 1'b0;
            ras_unf_q   <= 1'b0;
        end else begin
            pc_out_q    <= pc_out_d;
            link_addr_q <= link_addr_d;
            link_we_q   <= link_we_d;
            taken_q     <= taken_d;
            jump_done_q <= jump_done_d;
            addr_err_q  <= addr_err_d;
            ras_ptr_q   <= ras_ptr_d;
            ras_count_q <= ras_count_d;
            ras_ovf_q   <= ras_ovf_d;
            ras_unf_q   <= ras_unf_d;
        end
    end

    // Stack storage; contents are only meaningful below ras_count_q.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            ras_mem_q[ras_ptr_q] <= pc4;
        end
    end

    assign pc_out    = pc_out_q;
    assign link_addr = link_addr_q;
    assign link_we   = link_we_q;
    assign taken     = taken_q;
    assign jump_done = jump_done_q;
    assign addr_err  = addr_err_q;
    assign ras_count = ras_count_q;
    assign ras_ovf   = ras_ovf_q;
    assign ras_unf   = ras_unf_q;

endmodule

// File: tb/tb_branch_jump_unit.sv
// tb/tb_branch_jump_unit.sv - scoreboard bench for branch_jump_unit
module tb_branch_jump_unit;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [3:0]  path_index;
    logic [31:0] pc;
    logic [25:0] addr;
    logic [15:0] imm;
    logic        zero;
    logic [31:0] reg_addr;
    logic        use_ras;
    logic        clr_flags;
    logic [31:0] pc_out;
    logic [31:0] link_addr;
    logic        link_we;
    logic        taken;
    logic        jump_done;
    logic        addr_err;
    logic [2:0]  ras_count;
    logic        ras_ovf;
    logic        ras_unf;

    branch_jump_unit dut (
        .clk(clk), .rst_n(rst_n), .req(req), .path_index(path_index), .pc(pc),
        .addr(addr), .imm(imm), .zero(zero), .reg_addr(reg_addr), .use_ras(use_ras),
        .clr_flags(clr_flags), .pc_out(pc_out), .link_addr(link_addr), .link_we(link_we),
        .taken(taken), .jump_done(jump_done), .addr_err(addr_err), .ras_count(ras_count),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc_out;
        logic [31:0] link_addr;
        logic        link_we;
        logic        taken;
        logic        jump_done;
        logic        addr_err;
        logic [2:0]  ras_count;
        logic        ovf;
        logic        unf;
    } res_t;

    typedef struct packed {
        logic        rst_n;
        logic        req;
        logic [3:0]  op;
        logic [31:0] pc;
        logic [25:0] addr;
        logic [15:0] imm;
        logic        zero;
        logic [31:0] ra;
        logic        use_ras;
        logic        clr;
    } stim_t;

    res_t        sb[$];
    logic [31:0] ras_m[$];
    logic [31:0] m_pc, m_link;
    logic        m_taken, m_err, m_ovf, m_unf;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic res_t obs();
        res_t r;
        r = {pc_out, link_addr, link_we, taken, jump_done, addr_err, ras_count, ras_ovf, ras_unf};
        return r;
    endfunction

    function automatic stim_t S(input logic [3:0] op, input logic [31:0] p, input logic [25:0] a,
                                input logic [15:0] i, input logic z, input logic [31:0] r,
                                input logic u);
        stim_t s;
        s = '{rst_n: 1'b1, req: 1'b1, op: op, pc: p, addr: a, imm: i, zero: z, ra: r,
              use_ras: u, clr: 1'b0};
        return s;
    endfunction

    function automatic stim_t IDLE(input logic c);
        stim_t s;
        s = S(4'd0, 32'h0, 26'h0, 16'h0, 1'b0, 32'h0, 1'b0);
        s.req = 1'b0;
        s.clr = c;
        return s;
    endfunction

    // Drive one cycle of stimulus and push the behavioural model's expectation.
    task automatic apply(input stim_t s);
        res_t        e;
        logic [31:0] pc4, tgt;
        logic        so, su;
        rst_n = s.rst_n; req = s.req; path_index = s.op; pc = s.pc; addr = s.addr;
        imm = s.imm; zero = s.zero; reg_addr = s.ra; use_ras = s.use_ras; clr_flags = s.clr;
        e = '0;
        so = 1'b0;
        su = 1'b0;
        if (!s.rst_n) begin
            m_pc = 0; m_link = 0; m_taken = 0; m_err = 0; m_ovf = 0; m_unf = 0;
            ras_m.delete();
        end else begin
            if (s.req) begin
                pc4 = s.pc + 32'd4;
                m_pc = pc4; m_taken = 0; m_err = 0;
                case (s.op)
                    4'd3, 4'd4: if (s.zero == (s.op == 4'd3)) begin
                        m_pc = pc4 + {{14{s.imm[15]}}, s.imm, 2'b00};
                        m_taken = 1;
                    end
                    4'd5: begin
                        m_pc = {pc4[31:28], s.addr, 2'b00}; m_taken = 1;
                    end
                    4'd6: begin
                        m_pc = {pc4[31:28], s.addr, 2'b00}; m_taken = 1;
                        m_link = pc4; e.link_we = 1;
                        if (ras_m.size() == 4) begin
                            void'(ras_m.pop_front());
                            so = 1;
                        end
                        ras_m.push_back(pc4);
                    end
                    4'd8: begin
                        tgt = s.ra;
                        if (s.use_ras) begin
                            if (ras_m.size() > 0) tgt = ras_m.pop_back();
                            else su = 1;
                        end
                        if (tgt[1:0] != 2'b00) m_err = 1;
                        else begin m_pc = tgt; m_taken = 1; end
                    end
                    default: ;
                endcase
            end
            m_ovf = (m_ovf && !s.clr) || so;
            m_unf = (m_unf && !s.clr) || su;
            e.pc_out = m_pc; e.link_addr = m_link; e.taken = m_taken; e.addr_err = m_err;
            e.jump_done = s.req; e.ras_count = 3'(ras_m.size()); e.ovf = m_ovf; e.unf = m_unf;
        end
        sb.push_back(e);
    endtask

    task automatic test_reset();
        stim_t q[$];
        res_t  e;
        q.push_back(IDLE(1'b0)); q[0].rst_n = 1'b0;
        q.push_back(S(4'd6, 32'h10, 26'h5, 16'h0, 1'b0, 32'h0, 1'b0)); q[1].rst_n = 1'b0;
        foreach (q[i]) begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front(); n_cmp++;
                if (obs() !== e) begin n_bad++; $display("FAIL reset[%0d]: got %h want %h", i, obs(), e); end
            end
            apply(q[i]);
        end
    endtask

    task automatic test_jal();
        stim_t q[$];
        res_t  e;
        q.push_back(S(4'd6, 32'h00400000, 26'h0100040, 16'h0, 1'b0, 32'h0, 1'b1));
        q.push_back(IDLE(1'b0));
        q.push_back(S(4'd5, 32'hF0000000, 26'h3FFFFFF, 16'h0, 1'b0, 32'h0, 1'b1));
        q.push_back(IDLE(1'b0));
        foreach (q[i]) begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front(); n_cmp++;
                if (obs() !== e) begin n_bad++; $display("FAIL jal[%0d]: got %h want %h", i, obs(), e); end
            end
            apply(q[i]);
        end
    endtask

    task automatic test_branch();
        stim_t q[$];
        res_t  e;
        q.push_back(S(4'd3, 32'h00400010, 26'h0, 16'hFFFC, 1'b1, 32'h0, 1'b1));
        q.push_back(IDLE(1'b0));
        q.push_back(S(4'd3, 32'h00400010, 26'h0, 16'h0010, 1'b0, 32'h0, 1'b0));
        q.push_back(S(4'd4, 32'h00400010, 26'h0, 16'h0010, 1'b0, 32'h0, 1'b0));
        q.push_back(S(4'd4, 32'h00400010, 26'h0, 16'h0010, 1'b1, 32'h0, 1'b0));
        q.push_back(S(4'd3, 32'hFFFFFFFC, 26'h0, 16'h0001, 1'b1, 32'h0, 1'b0));
        q.push_back(S(4'd4, 32'h00000000, 26'h0, 16'h8000, 1'b0, 32'h0, 1'b0));
        q.push_back(IDLE(1'b0));
        foreach (q[i]) begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front(); n_cmp++;
                if (obs() !== e) begin n_bad++; $display("FAIL branch[%0d]: got %h want %h", i, obs(), e); end
            end
            apply(q[i]);
        end
    endtask

    task automatic test_ras();
        stim_t q[$];
        res_t  e;
        q.push_back(IDLE(1'b0)); q[0].rst_n = 1'b0;
        for (int k = 0; k < 5; k++)
            q.push_back(S(4'd6, 32'h00400000 + 32'(k * 16), 26'h0000100, 16'h0, 1'b0, 32'h0, 1'b0));
        for (int k = 0; k < 5; k++)
            q.push_back(S(4'd8, 32'h00500000, 26'h0, 16'h0, 1'b0, 32'h00600000, 1'b1));
        q.push_back(IDLE(1'b1));
        q.push_back(IDLE(1'b0));
        q.push_back(S(4'd8, 32'h00500000, 26'h0, 16'h0, 1'b0, 32'h00600008, 1'b1));
        q[$].clr = 1'b1;
        q.push_back(IDLE(1'b1));
        q.push_back(IDLE(1'b0));
        foreach (q[i]) begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front(); n_cmp++;
                if (obs() !== e) begin n_bad++; $display("FAIL ras[%0d]: got %h want %h", i, obs(), e); end
            end
            apply(q[i]);
        end
    endtask

    task automatic test_jr_misaligned();
        stim_t q[$];
        res_t  e;
        q.push_back(S(4'd8, 32'h00400020, 26'h0, 16'h0, 1'b0, 32'h00400102, 1'b0));
        q.push_back(S(4'd8, 32'h00400020, 26'h0, 16'h0, 1'b0, 32'h00400100, 1'b0));
        q.push_back(S(4'd8, 32'h00400020, 26'h0, 16'h0, 1'b0, 32'h00400101, 1'b0));
        q.push_back(IDLE(1'b0));
        foreach (q[i]) begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front(); n_cmp++;
                if (obs() !== e) begin n_bad++; $display("FAIL jr_align[%0d]: got %h want %h", i, obs(), e); end
            end
            apply(q[i]);
        end
    endtask

    task automatic test_back_to_back();
        stim_t q[$];
        res_t  e;
        q.push_back(S(4'd5, 32'h00400000, 26'h0000200, 16'h0, 1'b0, 32'h0, 1'b0));
        q.push_back(S(4'd4, 32'h00400800, 26'h0, 16'h0040, 1'b1, 32'h0, 1'b0));
        q.push_back(S(4'd0, 32'h00400900, 26'h0, 16'h0040, 1'b0, 32'h0, 1'b1));
        q.push_back(IDLE(1'b0));
        foreach (q[i]) begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front(); n_cmp++;
                if (obs() !== e) begin n_bad++; $display("FAIL b2b[%0d]: got %h want %h", i, obs(), e); end
            end
            apply(q[i]);
        end
    endtask

    task automatic test_reset_mid();
        stim_t q[$];
        res_t  e;
        q.push_back(S(4'd6, 32'h00400000, 26'h0000100, 16'h0, 1'b0, 32'h0, 1'b0));
        q.push_back(S(4'd6, 32'h00400040, 26'h0000100, 16'h0, 1'b0, 32'h0, 1'b0));
        q[1].rst_n = 1'b0;
        q.push_back(S(4'd6, 32'h00400080, 26'h0000100, 16'h0, 1'b0, 32'h0, 1'b0));
        q.push_back(IDLE(1'b0));
        foreach (q[i]) begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front(); n_cmp++;
                if (obs() !== e) begin n_bad++; $display("FAIL reset_mid[%0d]: got %h want %h", i, obs(), e); end
            end
            apply(q[i]);
        end
    endtask

    task automatic test_random();
        stim_t q[$];
        stim_t s;
        res_t  e;
        for (int k = 0; k < 60; k++) begin
            s = S(4'($urandom_range(0, 15)), $urandom, 26'($urandom), 16'($urandom),
                  1'($urandom), $urandom, 1'($urandom));
            if (k % 3 != 0) s.op = ($urandom_range(0, 1) == 1) ? 4'd6 : 4'd8;
            if ($urandom_range(0, 3) != 0) s.ra[1:0] = 2'b00;
            s.req = ($urandom_range(0, 4) != 0);
            s.clr = ($urandom_range(0, 7) == 0);
            q.push_back(s);
        end
        q.push_back(IDLE(1'b0));
        foreach (q[i]) begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front(); n_cmp++;
                if (obs() !== e) begin n_bad++; $display("FAIL random[%0d]: got %h want %h", i, obs(), e); end
            end
            apply(q[i]);
        end
    endtask

    initial begin
        res_t e;
        rst_n = 1'b0; req = 1'b0; path_index = '0; pc = '0; addr = '0; imm = '0;
        zero = 1'b0; reg_addr = '0; use_ras = 1'b0; clr_flags = 1'b0;
        test_reset();
        test_jal();
        test_branch();
        test_ras();
        test_jr_misaligned();
        test_back_to_back();
        test_reset_mid();
        test_random();
        @(negedge clk);
        if (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            if (obs() !== e) begin n_bad++; $display("FAIL drain: got %h want %h", obs(), e); end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
